// File: rtl/dp_arbiter.sv
// Three-way round-robin arbiter for the data-path bus control unit.
// One transfer in flight at a time; a toggle on dp_req starts each one.
module dp_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              ce_1,
  input  logic              ce_2,
  input  logic [2:0]        r_req,
  input  logic [DATA_W-1:0] r_addr [3],
  input  logic [DATA_W-1:0] r_dout [3],
  input  logic [1:0]        r_sreg [3],
  input  logic [2:0]        r_write,
  input  logic [2:0]        r_wide,
  input  logic [2:0]        r_io,
  input  logic [2:0]        r_zero_seg,
  input  logic [2:0]        r_lock,
  output logic [2:0]        r_ack,
  output logic [DATA_W-1:0] r_din,
  output logic [1:0]        grant,
  output logic [DATA_W-1:0] dp_addr,
  output logic [DATA_W-1:0] dp_dout,
  output logic [1:0]        dp_sreg,
  output logic              dp_write,
  output logic              dp_wide,
  output logic              dp_io,
  output logic              dp_zero_seg,
  output logic              dp_req,
  input  logic              dp_ready,
  input  logic [DATA_W-1:0] dp_din
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] NO_GRANT  = 2'd3;

  logic [1:0] state;
  logic [1:0] rr;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] win;
  logic [1:0] issue_idx;
  logic       do_issue;
  logic       en;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign en = ce_1 | ce_2;

  // Search order after the last owner: rr+1, rr+2, then rr itself.
  always_comb begin
    cand1 = next_idx(rr);
    cand2 = next_idx(cand1);
    if (r_req[cand1])      win = cand1;
    else if (r_req[cand2]) win = cand2;
    else                   win = rr;
  end

  always_comb begin
    issue_idx = (state == ST_LOCKED) ? grant : win;
    do_issue  = 1'b0;
    if (state == ST_IDLE)
      do_issue = |r_req;
    else if (state == ST_LOCKED)
      do_issue = r_lock[grant] & r_req[grant];
  end

  always_ff @(posedge clk) begin
    r_ack <= '0;
    if (!n_reset) begin
      state       <= ST_IDLE;
      dp_req      <= 1'b0;
      grant       <= NO_GRANT;
      rr          <= 2'd2;
      r_din       <= '1;
      dp_addr     <= '0;
      dp_dout     <= '0;
      dp_sreg     <= '0;
      dp_write    <= 1'b0;
      dp_wide     <= 1'b0;
      dp_io       <= 1'b0;
      dp_zero_seg <= 1'b0;
    end else if (en) begin
      if (do_issue) begin
        dp_addr     <= r_addr[issue_idx];
        dp_dout     <= r_dout[issue_idx];
        dp_sreg     <= r_sreg[issue_idx];
        dp_write    <= r_write[issue_idx];
        dp_wide     <= r_wide[issue_idx];
        dp_io       <= r_io[issue_idx];
        dp_zero_seg <= r_zero_seg[issue_idx];
        dp_req      <= ~dp_req;
        grant       <= issue_idx;
        state       <= ST_BUSY;
      end else begin
        case (state)
          ST_IDLE: grant <= NO_GRANT;
          // dp_ready only counts after the issuing edge has passed.
          ST_BUSY: begin
            if (dp_ready) begin
              if (!dp_write)
                r_din <= dp_din;
              r_ack[grant] <= 1'b1;
              rr           <= grant;
              if (r_lock[grant]) begin
                state <= ST_LOCKED;
              end else begin
                state <= ST_IDLE;
                grant <= NO_GRANT;
              end
            end
          end
          ST_LOCKED: begin
            if (!r_lock[grant]) begin
              state <= ST_IDLE;
              grant <= NO_GRANT;
            end
          end
          default: begin
            state <= ST_IDLE;
            grant <= NO_GRANT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dp_arbiter.sv
// Randomized bench for dp_arbiter: transaction-level reference model feeds a
// scoreboard that a separate monitor drains against the DUT outputs.
module tb_dp_arbiter;

  logic        clk;
  logic        n_reset;
  logic        ce_1, ce_2;
  logic [2:0]  r_req;
  logic [15:0] r_addr [3];
  logic [15:0] r_dout [3];
  logic [1:0]  r_sreg [3];
  logic [2:0]  r_write, r_wide, r_io, r_zero_seg, r_lock;
  logic [2:0]  r_ack;
  logic [15:0] r_din;
  logic [1:0]  grant;
  logic [15:0] dp_addr, dp_dout;
  logic [1:0]  dp_sreg;
  logic        dp_write, dp_wide, dp_io, dp_zero_seg, dp_req;
  logic        dp_ready;
  logic [15:0] dp_din;

  dp_arbiter #(.DATA_W(16)) dut (
    .clk(clk), .n_reset(n_reset), .ce_1(ce_1), .ce_2(ce_2),
    .r_req(r_req), .r_addr(r_addr), .r_dout(r_dout), .r_sreg(r_sreg),
    .r_write(r_write), .r_wide(r_wide), .r_io(r_io), .r_zero_seg(r_zero_seg),
    .r_lock(r_lock), .r_ack(r_ack), .r_din(r_din), .grant(grant),
    .dp_addr(dp_addr), .dp_dout(dp_dout), .dp_sreg(dp_sreg),
    .dp_write(dp_write), .dp_wide(dp_wide), .dp_io(dp_io),
    .dp_zero_seg(dp_zero_seg), .dp_req(dp_req), .dp_ready(dp_ready),
    .dp_din(dp_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [1:0]  sreg;
    logic        write, wide, io, zs;
  } issue_t;

  typedef struct {
    int          owner;
    logic [15:0] data;
  } ack_t;

  issue_t issue_q[$];
  ack_t   ack_q[$];
  int     grant_log[$];
  int     checks = 0;
  int     errors = 0;

  // Stimulus knobs
  int ce_pct = 100;
  int req_pct = 0;
  bit all_mode = 0;
  bit lock_mode = 0;
  int lock_left [3];

  // Bus control unit: acknowledges each toggle after a random delay
  logic bcu_tog = 1'b0;
  int   bcu_cnt = 0;
  int   rst_count = 0;
  int   rst_seen = 0;
  assign dp_ready = (dp_req == bcu_tog);

  always @(negedge clk) begin
    if (rst_count != rst_seen) begin
      rst_seen = rst_count;
      bcu_tog  = 1'b0;
      bcu_cnt  = $urandom_range(3);
    end else if (dp_req != bcu_tog) begin
      if (bcu_cnt == 0) begin
        bcu_tog = dp_req;
        dp_din  = 16'($urandom);
        bcu_cnt = $urandom_range(3);
      end else begin
        bcu_cnt--;
      end
    end
  end

  task automatic new_desc(input int i);
    r_addr[i]     = 16'($urandom);
    r_dout[i]     = 16'($urandom);
    r_sreg[i]     = 2'($urandom_range(3));
    r_write[i]    = 1'($urandom_range(1));
    r_wide[i]     = 1'($urandom_range(1));
    r_io[i]       = 1'($urandom_range(1));
    r_zero_seg[i] = 1'($urandom_range(1));
  endtask

  // Requesters: level requests held until acknowledged
  always @(negedge clk) begin
    ce_1 = ($urandom_range(99) < ce_pct);
    ce_2 = ($urandom_range(99) < ce_pct / 4);
    for (int i = 0; i < 3; i++) begin
      if (r_ack[i]) begin
        if (lock_left[i] > 0) begin
          lock_left[i]--;
          new_desc(i);
        end else if (all_mode) begin
          new_desc(i);
        end else begin
          r_req[i] = 1'b0;
        end
      end else if (!r_req[i]) begin
        if ($urandom_range(99) < req_pct) begin
          r_req[i] = 1'b1;
          new_desc(i);
          lock_left[i] = (lock_mode && $urandom_range(2) == 0) ? $urandom_range(2, 1) : 0;
        end
      end else if (!all_mode && $urandom_range(99) < 2) begin
        r_req[i] = 1'b0;
      end
      r_lock[i] = (lock_left[i] > 0);
    end
  end

  // Reference model: who owns the bus, who was served last, what was read
  localparam int M_IDLE = 0, M_BUSY = 1, M_LOCKED = 2;
  int          m_state = M_IDLE;
  int          m_owner = 3;
  int          m_last = 2;
  bit          m_wr = 0;
  logic [15:0] m_rdata = 16'hffff;

  function automatic int pick_winner(input int last, input logic [2:0] req);
    for (int k = 1; k <= 3; k++)
      if (req[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  task automatic model_issue(input int w);
    issue_t t;
    t.owner = w;
    t.addr  = r_addr[w];
    t.dout  = r_dout[w];
    t.sreg  = r_sreg[w];
    t.write = r_write[w];
    t.wide  = r_wide[w];
    t.io    = r_io[w];
    t.zs    = r_zero_seg[w];
    issue_q.push_back(t);
    m_wr    = r_write[w];
    m_owner = w;
    m_state = M_BUSY;
  endtask

  always @(posedge clk) begin
    int   w;
    ack_t a;
    if (!n_reset) begin
      m_state = M_IDLE; m_owner = 3; m_last = 2; m_rdata = 16'hffff;
    end else if (ce_1 || ce_2) begin
      if (m_state == M_IDLE) begin
        w = pick_winner(m_last, r_req);
        if (w >= 0) model_issue(w);
      end else if (m_state == M_BUSY) begin
        if (dp_ready) begin
          if (!m_wr) m_rdata = dp_din;
          a.owner = m_owner;
          a.data  = m_rdata;
          ack_q.push_back(a);
          m_last = m_owner;
          if (r_lock[m_owner]) m_state = M_LOCKED;
          else begin m_state = M_IDLE; m_owner = 3; end
        end
      end else begin
        if (!r_lock[m_owner]) begin m_state = M_IDLE; m_owner = 3; end
        else if (r_req[m_owner]) model_issue(m_owner);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares what the DUT presents against the scoreboard
  logic prev_dp_req = 1'b0;
  always @(posedge clk) begin
    issue_t t;
    ack_t   a;
    #1;
    if (!n_reset) begin
      rst_count++;
      chk("rst_grant", 32'(grant), 32'd3);
      chk("rst_dp_req", 32'(dp_req), 32'd0);
      chk("rst_ack", 32'(r_ack), 32'd0);
      chk("rst_r_din", 32'(r_din), 32'hffff);
      chk("rst_desc", {dp_addr, dp_dout}, 32'd0);
      chk("rst_desc_bits", {27'd0, dp_sreg, dp_write, dp_wide, dp_io}, 32'd0);
      issue_q.delete();
      ack_q.delete();
      prev_dp_req = 1'b0;
    end else begin
      chk("grant", 32'(grant), 32'(m_owner));
      if (dp_req != prev_dp_req) begin
        grant_log.push_back(int'(grant));
        if (issue_q.size() == 0) begin
          chk("unexpected_issue", 32'(dp_req), 32'(prev_dp_req));
        end else begin
          t = issue_q.pop_front();
          chk("issue_grant", 32'(grant), 32'(t.owner));
          chk("dp_addr_dout", {dp_addr, dp_dout}, {t.addr, t.dout});
          chk("dp_bits", {25'd0, dp_sreg, dp_write, dp_wide, dp_io, dp_zero_seg},
              {25'd0, t.sreg, t.write, t.wide, t.io, t.zs});
        end
      end else if (issue_q.size() != 0) begin
        t = issue_q.pop_front();
        chk("missing_issue", 32'(dp_req), 32'(~prev_dp_req));
      end
      prev_dp_req = dp_req;
      if (r_ack != 3'b000) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", 32'(r_ack), 32'd0);
        end else begin
          a = ack_q.pop_front();
          chk("ack_onehot", 32'(r_ack), 32'(3'b001 << a.owner));
          chk("r_din", 32'(r_din), 32'(a.data));
        end
      end else if (ack_q.size() != 0) begin
        a = ack_q.pop_front();
        chk("missing_ack", 32'(r_ack), 32'(3'b001 << a.owner));
      end
    end
  end

  initial begin
    n_reset = 1'b0;
    ce_1 = 1'b0; ce_2 = 1'b0;
    r_req = '0; r_lock = '0;
    r_write = '0; r_wide = '0; r_io = '0; r_zero_seg = '0;
    dp_din = 16'h0;
    for (int i = 0; i < 3; i++) begin
      r_addr[i] = '0; r_dout[i] = '0; r_sreg[i] = '0; lock_left[i] = 0;
    end
    repeat (3) @(negedge clk);

    // All three requesting from reset: expect 0,1,2,0
    all_mode = 1; req_pct = 100; ce_pct = 100;
    grant_log.delete();
    n_reset = 1'b1;
    repeat (60) @(negedge clk);
    chk("order_len_ok", 32'(grant_log.size() >= 4), 32'd1);
    if (grant_log.size() >= 4) begin
      chk("order0", 32'(grant_log[0]), 32'd0);
      chk("order1", 32'(grant_log[1]), 32'd1);
      chk("order2", 32'(grant_log[2]), 32'd2);
      chk("order3", 32'(grant_log[3]), 32'd0);
    end

    // Contention with locks, gated enables and sporadic resets
    all_mode = 1; lock_mode = 1; ce_pct = 70;
    repeat (1500) begin
      @(negedge clk);
      n_reset = ($urandom_range(199) != 0);
    end

    all_mode = 0; req_pct = 30;
    repeat (1500) begin
      @(negedge clk);
      n_reset = ($urandom_range(249) != 0);
    end

    // Long enable-low stretches so dp_ready waits on frozen state
    ce_pct = 8;
    repeat (1500) begin
      @(negedge clk);
      n_reset = ($urandom_range(399) != 0);
    end

    n_reset = 1'b1;
    req_pct = 0; lock_mode = 0; ce_pct = 100;
    repeat (100) @(negedge clk);
    chk("scoreboard_drained", 32'(issue_q.size() + ack_q.size()), 32'd0);
    chk("final_idle_grant", 32'(grant), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_arbiter.md
DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named as follows. clk  in  1  rising-edge clock for all state.
REQ-002 n_reset  in  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-003 ce_1, ce_2  in  1 each  phase clock enables; state advances only on clk edges where ce_1|ce_2 (an "enabled edge").
REQ-004 r_req[3]  in  1 each  level request from requester i (0=execution unit, 1=string unit, 2=stack/interrupt push).
REQ-005 r_addr[3] 16, r_dout[3] 16, r_sreg[3] sreg_index_e, r_write[3] 1, r_wide[3] 1, r_io[3] 1, r_zero_seg[3] 1  in  per-requester transfer descriptor.
REQ-006 r_lock[3]  in  1 each  hold the grant after completion, for multi-transfer sequences.
REQ-007 r_ack[3]  out  1 each  one-clk completion pulse to requester i.
REQ-008 r_din  out  16  read data from the last completed transfer, shared by all requesters.
REQ-009 grant  out  2  current owner index (0..2); value 3 = none.
REQ-010 dp_addr 16, dp_dout 16, dp_sreg, dp_write 1, dp_wide 1, dp_io 1, dp_zero_seg 1  out  registered descriptor to the bus control unit.
REQ-011 dp_req  out  1  toggle request; one toggle = one transfer.
REQ-012 dp_ready  in  1  high when the bus control unit has acknowledged the last toggle.
REQ-013 dp_din  in  16  read data from the bus control unit.

Function
REQ-014 States SHALL be IDLE, BUSY and LOCKED; all transitions occur only on enabled edges.
REQ-015 IDLE, any r_req high: select winner by round-robin, search order rr+1, rr+2, rr (mod 3); latch the winner's descriptor into the dp_* registers; toggle dp_req; set grant; go to BUSY; all in the same edge.
REQ-016 IDLE, no r_req high: dp_req unchanged, grant=3.
REQ-017 dp_* descriptor outputs SHALL hold constant from the issuing edge until the next issue; requester inputs are not sampled while BUSY.
REQ-018 BUSY: dp_ready is ignored on the issuing edge itself; on a later enabled edge with dp_ready=1, r_din<=dp_din (reads only; r_din is unchanged on writes), r_ack[grant] pulses for exactly one clk, and rr<=grant.
REQ-019 Completion with r_lock[grant]=1 SHALL go to LOCKED; otherwise it SHALL go to IDLE with grant=3.
REQ-020 LOCKED: only requester grant may issue, with the same issue rules as REQ-015; other requesters are ignored. When r_lock[grant]=0, the block SHALL go to IDLE on that edge with grant=3, and arbitration resumes on the next enabled edge.
REQ-021 Issue-to-ack latency SHALL be the bus control unit latency plus at most one enabled edge; there are no idle bubbles beyond the IDLE re-arbitration edge.
REQ-022 If r_req of the granted requester drops while BUSY, the transfer SHALL still complete and r_ack still pulses.
REQ-023 A completion and a new request on the same edge: the new request is considered on the following enabled edge, never in the completion edge.
REQ-024 At most one toggle SHALL be outstanding, so dp_req never toggles while BUSY.
REQ-025 r_ack SHALL be low on all non-enabled edges except the completion pulse, and never high for two requesters at once.
REQ-026 Clock enables low SHALL freeze all state; pending dp_ready is then seen on the next enabled edge.

Reset
REQ-027 On a clk edge with n_reset=0: state=IDLE, dp_req=0, grant=3, rr=2 (requester 0 first), r_ack=0, r_din=16'hffff, dp_* descriptor=0.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no r_ack; the bus control unit is reset concurrently, so dp_req=0 matches its ack.

Verification
REQ-029 All three r_req high from reset -> grants in order 0,1,2,0, each r_ack a single-clk pulse, dp_req toggling once per grant.
REQ-030 Requester 1 read, addr 16'h1235, wide=1, dp_din=16'hBEEF at ready -> r_din=16'hBEEF, r_ack[1]=1 for one clk, dp_addr stable throughout.
REQ-031 Requester 2 with r_lock=1 for 2 transfers while r_req[0]=1 -> both transfers go to 2, then requester 0 is granted after lock drops.
REQ-032 n_reset=0 while BUSY -> no r_ack, dp_req=0, grant=3 next edge, fresh arbitration starting at requester 0.
REQ-033 ce_1=ce_2=0 for 10 clks with dp_ready=1 -> no ack until the first enabled edge; exactly one ack then.
